// File: rtl/reg_proto_pkg.sv
// rtl/reg_proto_pkg.sv - shared constants, state encoding and command byte helper for the register-access protocol
package reg_proto_pkg;

    localparam logic [7:0] REG_MAGIC       = 8'hAA;
    localparam logic       REG_TYPE_RD     = 1'b0;
    localparam logic       REG_TYPE_WR     = 1'b1;
    localparam int         REG_CMD_BYTES   = 8;
    localparam int         REG_REPLY_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_COLLECT,
        ST_DONE
    } master_state_t;

    // Command layout: magic, type, address LE, data LE.
    function automatic logic [7:0] cmd_byte(
        input logic [2:0]  idx,
        input logic        wr,
        input logic [15:0] addr,
        input logic [31:0] data
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = REG_MAGIC;
            3'd1:    b = {7'b0, wr};
            3'd2:    b = addr[7:0];
            3'd3:    b = addr[15:8];
            3'd4:    b = data[7:0];
            3'd5:    b = data[15:8];
            3'd6:    b = data[23:16];
            default: b = data[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/reg_cmd_master_if.sv
// rtl/reg_cmd_master_if.sv - request, command byte, reply byte and response signals of the register command master
interface reg_cmd_master_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [31:0] req_data;

    logic [7:0]  cmd_out;
    logic        cmd_wr;
    logic        cmd_ready;

    logic [7:0]  reply_in;
    logic        reply_rdy;
    logic        reply_ack;
    logic        reply_end;

    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;

    modport master (
        input  req_valid, req_wr, req_addr, req_data,
        input  cmd_ready,
        input  reply_in, reply_rdy, reply_end,
        output req_ready,
        output cmd_out, cmd_wr,
        output reply_ack,
        output resp_valid, resp_data, resp_err
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_data,
        output cmd_ready,
        output reply_in, reply_rdy, reply_end,
        input  req_ready,
        input  cmd_out, cmd_wr,
        input  reply_ack,
        input  resp_valid, resp_data, resp_err
    );

endinterface

// File: rtl/reg_reply_collector.sv
// rtl/reg_reply_collector.sv - gathers the 4-byte LE reply, checks reply_end framing and times out stalled replies
module reg_reply_collector
    import reg_proto_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TCNT_W         = 11
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        active,
    input  logic [7:0]  reply_in,
    input  logic        reply_rdy,
    input  logic        reply_end,
    output logic        reply_ack,
    output logic        done,
    output logic        err,
    output logic [31:0] data
);

    localparam logic [1:0]        LAST_REPLY = 2'(REG_REPLY_BYTES - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST  = TCNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]        ri;
    logic [TCNT_W-1:0] tcnt;
    logic [TCNT_W-1:0] tcnt_inc;
    logic              timeout;

    assign reply_ack = active && reply_rdy;
    assign tcnt_inc  = tcnt + 1'b1;
    assign timeout   = active && !reply_rdy && (tcnt_inc == TCNT_LAST);

    // The final byte must carry reply_end; any earlier reply_end is a framing error.
    always_comb begin
        done = 1'b0;
        err  = 1'b0;
        if (reply_ack) begin
            if (ri == LAST_REPLY) begin
                done = 1'b1;
                err  = !reply_end;
            end else if (reply_end) begin
                done = 1'b1;
                err  = 1'b1;
            end
        end else if (timeout) begin
            done = 1'b1;
            err  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ri   <= '0;
            tcnt <= '0;
            data <= '0;
        end else if (start) begin
            ri   <= '0;
            tcnt <= '0;
        end else if (reply_ack) begin
            data[{ri, 3'b000} +: 8] <= reply_in;
            ri                      <= ri + 2'd1;
            tcnt                    <= '0;
        end else if (active) begin
            tcnt <= tcnt_inc;
            if (timeout) begin
                data <= '0;
            end
        end
    end

endmodule

// File: rtl/reg_cmd_master.sv
// rtl/reg_cmd_master.sv - serialises a register request into the 8-byte command and returns the assembled reply
module reg_cmd_master
    import reg_proto_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TCNT_W         = 11
) (
    input  logic             clk,
    input  logic             reset_n,
    reg_cmd_master_if.master bus
);

    localparam logic [2:0] LAST_CMD = 3'(REG_CMD_BYTES - 1);

    master_state_t state;
    logic [2:0]    bi;
    logic          lat_wr;
    logic [15:0]   lat_addr;
    logic [31:0]   lat_data;
    logic          resp_valid_q;
    logic          resp_err_q;

    logic          cmd_fire;
    logic          collecting;
    logic          col_start;
    logic          col_done;
    logic          col_err;
    logic          col_ack;
    logic [31:0]   col_data;

    assign cmd_fire   = (state == ST_SEND) && bus.cmd_ready;
    assign collecting = (state == ST_COLLECT);
    assign col_start  = cmd_fire && (bi == LAST_CMD);

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.cmd_wr     = cmd_fire;
    assign bus.cmd_out    = cmd_byte(bi, lat_wr, lat_addr, lat_data);
    assign bus.reply_ack  = col_ack;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_data  = col_data;

    reg_reply_collector #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TCNT_W        (TCNT_W)
    ) u_collector (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (col_start),
        .active   (collecting),
        .reply_in (bus.reply_in),
        .reply_rdy(bus.reply_rdy),
        .reply_end(bus.reply_end),
        .reply_ack(col_ack),
        .done     (col_done),
        .err      (col_err),
        .data     (col_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            bi           <= '0;
            lat_wr       <= REG_TYPE_RD;
            lat_addr     <= '0;
            lat_data     <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        lat_wr   <= bus.req_wr;
                        lat_addr <= bus.req_addr;
                        // Reads carry an all-zero data field on the wire.
                        lat_data <= (bus.req_wr == REG_TYPE_WR) ? bus.req_data : 32'h0;
                        bi       <= '0;
                        state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (cmd_fire) begin
                        bi <= bi + 3'd1;
                        if (bi == LAST_CMD) begin
                            state <= ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (col_done) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= col_err;
                        state        <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_cmd_master.sv
// tb/tb_reg_cmd_master.sv - directed self-checking bench for reg_cmd_master
module tb_reg_cmd_master;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;

    logic [7:0]  cap [8];
    int          cap_cyc [8];
    int          n_cap;
    int          acc_cyc;
    logic        acc_ready;
    logic        got_resp;
    logic        r_err;
    logic [31:0] r_data;
    logic        valid_next;
    logic        ready_next;
    logic        last_ack;
    int          resp_cyc;
    int          last_byte_cyc;

    reg_cmd_master_if bus ();

    reg_cmd_master #(
        .TIMEOUT_CYCLES(16),
        .TCNT_W        (5)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    task automatic send_req(input logic wr, input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = a;
        bus.req_data  = d;
        #1;
        acc_ready = bus.req_ready;
        acc_cyc   = cyc;
    endtask

    task automatic capture_cmd();
        n_cap = 0;
        for (int i = 0; i < 8; i++) begin
            cap[i]     = 8'h00;
            cap_cyc[i] = -1;
        end
        for (int k = 0; k < 40 && n_cap < 8; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            #1;
            if (bus.cmd_wr === 1'b1) begin
                cap[n_cap]     = bus.cmd_out;
                cap_cyc[n_cap] = cyc - acc_cyc;
                n_cap++;
            end
        end
    endtask

    task automatic give_byte(input logic [7:0] b, input logic e);
        @(negedge clk);
        bus.reply_rdy = 1'b1;
        bus.reply_in  = b;
        bus.reply_end = e;
        #1;
        last_ack      = bus.reply_ack;
        last_byte_cyc = cyc;
    endtask

    task automatic give_word(input logic [31:0] w);
        give_byte(w[7:0], 1'b0);
        give_byte(w[15:8], 1'b0);
        give_byte(w[23:16], 1'b0);
        give_byte(w[31:24], 1'b1);
    endtask

    task automatic wait_resp(input int budget);
        got_resp = 1'b0;
        r_data   = 32'hx;
        r_err    = 1'bx;
        resp_cyc = -1;
        for (int k = 0; k < budget && !got_resp; k++) begin
            @(negedge clk);
            bus.reply_rdy = 1'b0;
            bus.reply_end = 1'b0;
            #1;
            if (bus.resp_valid === 1'b1) begin
                got_resp = 1'b1;
                r_data   = bus.resp_data;
                r_err    = bus.resp_err;
                resp_cyc = cyc;
            end
        end
        @(negedge clk);
        #1;
        valid_next = bus.resp_valid;
        ready_next = bus.req_ready;
    endtask

    task automatic test_reset();
        bus.reply_rdy = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b expected 1", bus.req_ready); end
        checks++; if (bus.cmd_wr !== 1'b0) begin errors++; $display("FAIL rst_cmd_wr: got %b expected 0", bus.cmd_wr); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b expected 0", bus.resp_valid); end
        checks++; if (bus.resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_err: got %b expected 0", bus.resp_err); end
        checks++; if (bus.resp_data !== 32'h0) begin errors++; $display("FAIL rst_resp_data: got %h expected 00000000", bus.resp_data); end
        checks++; if (bus.reply_ack !== 1'b0) begin errors++; $display("FAIL rst_reply_ack: got %b expected 0", bus.reply_ack); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++; if (bus.reply_ack !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL idle_ack_ready: got ack %b ready %b expected ack 0 ready 1", bus.reply_ack, bus.req_ready); end
        bus.reply_rdy = 1'b0;
    endtask

    task automatic test_write();
        logic [7:0] e [8];
        e = '{8'hAA, 8'h01, 8'h12, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_req(1'b1, 16'h0012, 32'hDEADBEEF);
        checks++; if (acc_ready !== 1'b1) begin errors++; $display("FAIL wr_accept: got req_ready %b expected 1", acc_ready); end
        capture_cmd();
        checks++; if (n_cap != 8) begin errors++; $display("FAIL wr_count: got %0d bytes expected 8", n_cap); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cap[i] !== e[i] || cap_cyc[i] != i + 1) begin
                errors++;
                $display("FAIL wr_byte%0d: got %h at +%0d expected %h at +%0d", i, cap[i], cap_cyc[i], e[i], i + 1);
            end
        end
        give_word(32'h0000_0001);
        checks++; if (last_ack !== 1'b1) begin errors++; $display("FAIL wr_reply_ack: got %b expected 1", last_ack); end
        wait_resp(8);
        checks++; if (got_resp !== 1'b1 || resp_cyc - last_byte_cyc != 1) begin errors++; $display("FAIL wr_resp_time: got valid %b after %0d expected 1 after 1", got_resp, resp_cyc - last_byte_cyc); end
        checks++; if (r_data !== 32'h0000_0001 || r_err !== 1'b0) begin errors++; $display("FAIL wr_resp: got %h err %b expected 00000001 err 0", r_data, r_err); end
        checks++; if (valid_next !== 1'b0 || ready_next !== 1'b1) begin errors++; $display("FAIL wr_after: got valid %b ready %b expected valid 0 ready 1", valid_next, ready_next); end
    endtask

    task automatic test_read();
        logic [7:0] e [8];
        e = '{8'hAA, 8'h00, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_req(1'b0, 16'h0012, 32'hFFFF_FFFF);
        capture_cmd();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cap[i] !== e[i] || cap_cyc[i] != i + 1) begin
                errors++;
                $display("FAIL rd_byte%0d: got %h at +%0d expected %h at +%0d", i, cap[i], cap_cyc[i], e[i], i + 1);
            end
        end
        give_word(32'h1234_5678);
        wait_resp(8);
        checks++; if (got_resp !== 1'b1 || resp_cyc - last_byte_cyc != 1) begin errors++; $display("FAIL rd_resp_time: got valid %b after %0d expected 1 after 1", got_resp, resp_cyc - last_byte_cyc); end
        checks++; if (r_data !== 32'h1234_5678 || r_err !== 1'b0) begin errors++; $display("FAIL rd_resp: got %h err %b expected 12345678 err 0", r_data, r_err); end
        checks++; if (valid_next !== 1'b0) begin errors++; $display("FAIL rd_single_pulse: got %b expected 0", valid_next); end
    endtask

    task automatic test_stall();
        logic [7:0] e [8];
        logic [7:0] got [8];
        int n         = 0;
        int stall_bad = 0;
        int rdy_bad   = 0;
        e = '{8'hAA, 8'h01, 8'h12, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 8; i++) got[i] = 8'h00;
        send_req(1'b1, 16'h0012, 32'h1122_3344);
        for (int c = 1; c <= 20 && n < 8; c++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            bus.cmd_ready = !(c >= 3 && c <= 5);
            #1;
            if (bus.req_ready !== 1'b0) rdy_bad++;
            if (c >= 3 && c <= 5) begin
                if (bus.cmd_wr !== 1'b0 || bus.cmd_out !== 8'h12) stall_bad++;
            end else if (bus.cmd_wr === 1'b1) begin
                got[n] = bus.cmd_out;
                n++;
            end
        end
        bus.cmd_ready = 1'b1;
        checks++; if (stall_bad != 0) begin errors++; $display("FAIL stall_hold: got %0d bad stall cycles expected 0", stall_bad); end
        checks++; if (rdy_bad != 0) begin errors++; $display("FAIL stall_req_ready: got %0d cycles with ready expected 0", rdy_bad); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got[i] !== e[i]) begin errors++; $display("FAIL stall_byte%0d: got %h expected %h", i, got[i], e[i]); end
        end
        give_word(32'h5566_7788);
        wait_resp(8);
        checks++; if (got_resp !== 1'b1 || r_data !== 32'h5566_7788 || r_err !== 1'b0) begin errors++; $display("FAIL stall_resp: got valid %b data %h err %b expected 1 55667788 0", got_resp, r_data, r_err); end
    endtask

    task automatic test_timeout();
        send_req(1'b0, 16'h0012, 32'h0);
        capture_cmd();
        give_byte(8'h78, 1'b0);
        give_byte(8'h56, 1'b0);
        wait_resp(40);
        checks++; if (got_resp !== 1'b1 || resp_cyc - last_byte_cyc != 16) begin errors++; $display("FAIL to_time: got valid %b after %0d expected 1 after 16", got_resp, resp_cyc - last_byte_cyc); end
        checks++; if (r_err !== 1'b1 || r_data !== 32'h0) begin errors++; $display("FAIL to_resp: got err %b data %h expected err 1 data 00000000", r_err, r_data); end
        checks++; if (valid_next !== 1'b0 || ready_next !== 1'b1) begin errors++; $display("FAIL to_idle: got valid %b ready %b expected 0 1", valid_next, ready_next); end
    endtask

    task automatic test_early_end();
        send_req(1'b0, 16'h0021, 32'h0);
        capture_cmd();
        give_byte(8'h11, 1'b0);
        give_byte(8'h22, 1'b1);
        wait_resp(8);
        checks++; if (got_resp !== 1'b1 || resp_cyc - last_byte_cyc != 1) begin errors++; $display("FAIL early_time: got valid %b after %0d expected 1 after 1", got_resp, resp_cyc - last_byte_cyc); end
        checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL early_err: got %b expected 1", r_err); end
        checks++; if (ready_next !== 1'b1) begin errors++; $display("FAIL early_idle: got ready %b expected 1", ready_next); end
    endtask

    task automatic test_back_to_back();
        send_req(1'b0, 16'h0030, 32'h0);
        capture_cmd();
        give_byte(8'h01, 1'b0);
        give_byte(8'h02, 1'b0);
        give_byte(8'h03, 1'b0);
        give_byte(8'h04, 1'b0);
        @(negedge clk);
        bus.reply_rdy = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_addr  = 16'h0034;
        #1;
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1) begin errors++; $display("FAIL noend_err: got valid %b err %b expected 1 1", bus.resp_valid, bus.resp_err); end
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL done_ready: got %b expected 0", bus.req_ready); end
        @(negedge clk);
        #1;
        checks++; if (bus.req_ready !== 1'b1 || bus.cmd_wr !== 1'b0) begin errors++; $display("FAIL idle_after_done: got ready %b cmd_wr %b expected 1 0", bus.req_ready, bus.cmd_wr); end
        acc_cyc = cyc;
        capture_cmd();
        checks++; if (n_cap != 8 || cap_cyc[0] != 1 || cap[2] !== 8'h34) begin errors++; $display("FAIL b2b_cmd: got %0d bytes first +%0d addr %h expected 8 +1 34", n_cap, cap_cyc[0], cap[2]); end
        give_word(32'hA5A5_0F0F);
        wait_resp(8);
        checks++; if (got_resp !== 1'b1 || r_data !== 32'hA5A5_0F0F || r_err !== 1'b0) begin errors++; $display("FAIL b2b_resp: got valid %b data %h err %b expected 1 a5a50f0f 0", got_resp, r_data, r_err); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        logic [7:0] e [8];
        e = '{8'hAA, 8'h00, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_req(1'b1, 16'h0040, 32'hCAFE_F00D);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
        end
        #1;
        checks++; if (bus.cmd_wr !== 1'b1 || bus.cmd_out !== 8'hF0) begin errors++; $display("FAIL mid_byte5: got wr %b out %h expected 1 f0", bus.cmd_wr, bus.cmd_out); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (bus.cmd_wr !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL mid_async: got wr %b ready %b expected 0 1", bus.cmd_wr, bus.req_ready); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++; if (bus.cmd_wr !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_data !== 32'h0) begin errors++; $display("FAIL mid_release: got wr %b ready %b data %h expected 0 1 00000000", bus.cmd_wr, bus.req_ready, bus.resp_data); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (bus.resp_valid !== 1'b0 || bus.cmd_wr !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL mid_quiet: got %0d active cycles expected 0", seen); end
        send_req(1'b0, 16'h0055, 32'h0);
        capture_cmd();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cap[i] !== e[i] || cap_cyc[i] != i + 1) begin
                errors++;
                $display("FAIL post_byte%0d: got %h at +%0d expected %h at +%0d", i, cap[i], cap_cyc[i], e[i], i + 1);
            end
        end
        give_word(32'h0BAD_F00D);
        wait_resp(8);
        checks++; if (got_resp !== 1'b1 || r_data !== 32'h0BAD_F00D || r_err !== 1'b0) begin errors++; $display("FAIL post_resp: got valid %b data %h err %b expected 1 0badf00d 0", got_resp, r_data, r_err); end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = 16'h0;
        bus.req_data  = 32'h0;
        bus.cmd_ready = 1'b1;
        bus.reply_in  = 8'h0;
        bus.reply_rdy = 1'b0;
        bus.reply_end = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_stall();
        test_timeout();
        test_early_end();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
